// File: rtl/instruction_fetch.sv
// Instruction fetch: PC generation, imem request/response tracking and a small buffer
// feeding the decoder over valid/ready. Optional FETCH_MISALIGN_CHECK_EN adds fetch_fault.
module instruction_fetch #(
  parameter int unsigned        XLEN       = 32,
  parameter logic [XLEN-1:0]    RESET_PC   = '0,
  parameter int unsigned        FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            fetch_fault
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW:0] DepthVal = (CntW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d;
  logic [XLEN-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CntW-1:0] out_cnt_q, out_cnt_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CntW:0]   occupancy;
  logic [XLEN-1:0] target_pc;
  logic            gnt_fire, push, pop, req_block;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;

  always_comb begin
    fault_d = fault_q;
    if (redirect) fault_d = |redirect_pc[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end

  assign fetch_fault = fault_q;
  assign req_block   = fault_q;
`else
  assign req_block   = 1'b0;
`endif

  // Low address bits of a redirect target are never used to fetch.
  assign target_pc = redirect_pc & ~(XLEN'(3));

  // Outstanding requests plus buffered words may never exceed the buffer size.
  assign occupancy = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};

  assign imem_req    = en & ~redirect & ~req_block & (occupancy < DepthVal);
  assign imem_addr   = fetch_pc_q;
  assign gnt_fire    = imem_req & imem_gnt;
  assign instr_valid = (fifo_cnt_q != '0);
  assign instr       = mem_q[rd_ptr_q];
  assign instr_pc    = head_pc_q;
  assign pop         = instr_valid & instr_ready;
  assign push        = imem_rvalid & (drop_cnt_q == '0) & ~redirect;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    drop_cnt_d = drop_cnt_q;
    out_cnt_d  = out_cnt_q + CntW'(gnt_fire) - CntW'(imem_rvalid);

    if (gnt_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (imem_rvalid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CntW'(1);
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PtrW'(1);
      head_pc_d = head_pc_q + XLEN'(4);
    end
    fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);

    // Flush: everything still outstanding after this cycle belongs to the old path.
    if (redirect) begin
      fetch_pc_d = target_pc;
      head_pc_d  = target_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
      drop_cnt_d = out_cnt_q - CntW'(imem_rvalid);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: in-order memory model, transaction scoreboard of
// expected (pc, data) pairs, and directed steps for stalls, flushes and misaligned redirects.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n, en, imem_req, imem_gnt, imem_rvalid, redirect;
  logic        instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] model_pc = 32'h0;
  logic        mem_hold;
  int          errors = 0, checks = 0;
  int          grants = 0, pops = 0, cyc = 0, g0 = 0;
  int          first_gnt = -1, first_val = -1;

  instruction_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_fault (fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 30) begin
      tick(1);
      #1;
      n++;
    end
    check(tag, 32'(instr_valid), 32'd1);
  endtask

  // Stop granting and drain everything outstanding.
  task automatic quiet();
    imem_gnt    = 1'b0;
    instr_ready = 1'b1;
    mem_hold    = 1'b0;
    tick(6);
  endtask

  // Memory: in-order, one response per cycle, at least one cycle after grant.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && !mem_hold && mem_q.size() != 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_data(mem_q.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  // Monitor and scoreboard, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (instr_valid && instr_ready) begin
          if (first_val < 0) first_val = cyc;
          pops++;
          check("pop_has_expect", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("instr_pc", instr_pc, e.pc);
            check("instr", instr, e.data);
          end
        end
        if (redirect) begin
          check("req_in_redirect", 32'(imem_req), 32'd0);
          exp_q.delete();
          model_pc = redirect_pc & ~32'h3;
        end
        if (imem_req && imem_gnt) begin
          if (first_gnt < 0) first_gnt = cyc;
          grants++;
          mem_q.push_back(imem_addr);
          check("imem_addr", imem_addr, model_pc);
          exp_q.push_back('{pc: model_pc, data: mem_data(model_pc)});
          model_pc = model_pc + 32'd4;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1;
    redirect = 1'b0; redirect_pc = '0; mem_hold = 1'b0;
    tick(3);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_addr", imem_addr, 32'd0);

    // Free-running fetch from reset.
    rst_n = 1'b1; en = 1'b1;
    tick(12);
    check("first_valid_latency", 32'(first_val - first_gnt), 32'd2);
    check("t1_pops", 32'(pops >= 3), 32'd1);

    // Decoder stalled: only FIFO_DEPTH requests issue, then one pop frees one slot.
    quiet();
    imem_gnt = 1'b1; instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    tick(1);
    redirect = 1'b0;
    g0 = grants;
    tick(8);
    #1;
    check("stall_grants", 32'(grants - g0), 32'd2);
    check("stall_req", 32'(imem_req), 32'd0);
    check("stall_valid", 32'(instr_valid), 32'd1);
    check("stall_head_pc", instr_pc, 32'h40);
    instr_ready = 1'b1;
    tick(1);
    instr_ready = 1'b0;
    #1;
    check("resume_req", 32'(imem_req), 32'd1);
    check("resume_addr", imem_addr, 32'h48);
    tick(4);
    check("resume_grants", 32'(grants - g0), 32'd3);

    // Grant withheld: request and address stay put.
    quiet();
    redirect = 1'b1; redirect_pc = 32'h0;
    tick(1);
    redirect = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("nognt_req", 32'(imem_req), 32'd1);
      check("nognt_addr", imem_addr, 32'h0);
      tick(1);
    end
    g0 = grants;
    imem_gnt = 1'b1;
    tick(1);
    imem_gnt = 1'b0;
    #1;
    check("gnt_once", 32'(grants - g0), 32'd1);
    check("gnt_addr_adv", imem_addr, 32'h4);

    // Two requests in flight are dropped by a redirect.
    quiet();
    mem_hold = 1'b1; redirect = 1'b1; redirect_pc = 32'h8;
    tick(1);
    redirect = 1'b0; imem_gnt = 1'b1;
    g0 = grants;
    tick(4);
    #1;
    check("inflight_grants", 32'(grants - g0), 32'd2);
    check("inflight_valid", 32'(instr_valid), 32'd0);
    check("inflight_req", 32'(imem_req), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick(1);
    redirect = 1'b0;
    #1;
    check("post_redirect_valid", 32'(instr_valid), 32'd0);
    mem_hold = 1'b0;
    wait_valid("drop_then_valid");
    check("drop_head_pc", instr_pc, 32'h100);
    check("drop_head_instr", instr, mem_data(32'h100));

    // Redirect coinciding with rvalid and a pop, one entry buffered.
    quiet();
    instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
    tick(1);
    redirect = 1'b0; imem_gnt = 1'b1;
    tick(2);
    redirect = 1'b1; redirect_pc = 32'h400; instr_ready = 1'b1;
    #1;
    check("coinc_valid", 32'(instr_valid), 32'd1);
    check("coinc_head_pc", instr_pc, 32'h300);
    tick(1);
    redirect = 1'b0;
    #1;
    check("coinc_flushed", 32'(instr_valid), 32'd0);
    check("coinc_req", 32'(imem_req), 32'd1);
    check("coinc_addr", imem_addr, 32'h400);
    wait_valid("coinc_new_valid");
    check("coinc_new_pc", instr_pc, 32'h400);
    check("coinc_new_instr", instr, mem_data(32'h400));

    // Misaligned redirect target.
    quiet();
    imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h102;
`ifdef FETCH_MISALIGN_CHECK_EN
    tick(1);
    redirect = 1'b0;
    g0 = grants;
    #1;
    check("fault_set", 32'(fetch_fault), 32'd1);
    tick(4);
    check("fault_no_grants", 32'(grants - g0), 32'd0);
    check("fault_req", 32'(imem_req), 32'd0);
    check("fault_held", 32'(fetch_fault), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick(1);
    redirect = 1'b0;
    #1;
    check("fault_clear", 32'(fetch_fault), 32'd0);
    check("fault_resume_req", 32'(imem_req), 32'd1);
    check("fault_resume_addr", imem_addr, 32'h200);
`else
    redirect_pc = 32'h502;
    tick(1);
    redirect = 1'b0;
    #1;
    check("misalign_req", 32'(imem_req), 32'd1);
    check("misalign_addr", imem_addr, 32'h500);
`endif
    tick(4);

    // Fetch disabled: outstanding work drains, nothing new issues.
    en = 1'b0;
    tick(1);
    g0 = grants;
    tick(6);
    check("en_off_grants", 32'(grants - g0), 32'd0);
    check("en_off_req", 32'(imem_req), 32'd0);
    check("en_off_valid", 32'(instr_valid), 32'd0);
    check("en_off_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
